dpram_arb: RTL and testbench
============================

# dpram_arb

Round-robin arbiter and sequencer that shares one dual-port RAM (one registered read port, one byte-strobed write port) between N requesters. Read and write ports are arbitrated independently. Read responses are tagged back to the granted requester one cycle later. A same-cycle write to the address being read is forwarded into the read response, so the RAM behaves write-first to its users. Sits directly in front of the DPRAM instance in a shared-buffer or table subsystem.

## Interface

**Parameters**

- N, 2, number of requesters (≥1).
- A, 16, address width.
- D, 32, data width.
- S, 2, write-strobe lanes; D divisible by S; lane width E = D/S.

**Ports**

- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- rd_req  in  N  per-requester read request.
- rd_addr  in  N*A  read addresses; requester i at [i*A+:A].
- rd_gnt  out  N  read grant, one-hot or zero, combinational.
- rsp_vld  out  N  read response valid, one-hot or zero, registered.
- rsp_data  out  D  read response data, shared by all requesters.
- wr_req  in  N  per-requester write request.
- wr_addr  in  N*A  write addresses.
- wr_data  in  N*D  write data.
- wr_strb  in  N*S  write lane strobes.
- wr_gnt  out  N  write grant, one-hot or zero, combinational.
- ram_ren  out  1  to RAM read enable.
- ram_raddr  out  A  to RAM read address.
- ram_rdata  in  D  from RAM; valid the cycle after ram_ren.
- ram_wen  out  1  to RAM write enable.
- ram_waddr  out  A  to RAM write address.
- ram_wdata  out  D  to RAM write data.
- ram_wstrb  out  S  to RAM write strobes.

## Operation

- **Requester protocol:** request plus address/data held stable until the grant cycle. A grant completes the transfer in that cycle. Dropping a request before grant is legal and has no effect.
- **Read arbiter:**
  - Pointer rp (0..N-1, reset 0) marks the highest-priority index.
  - Grant goes to the first requester with rd_req set, scanning rp, rp+1, … modulo N.
  - On a grant to index g, rp ← (g+1) mod N. No grant leaves rp unchanged.
- **Write arbiter:** identical scheme with an independent pointer wp (reset 0).
- **RAM drive:**
  - ram_ren = |rd_gnt, with ram_raddr = granted rd_addr.
  - ram_wen = |wr_gnt, with ram_waddr, ram_wdata and ram_wstrb taken from the granted requester.
  - With no grant, the address and data outputs are don't-care, but must come from the lowest requester so they are deterministic.
- **Response tag:** the registered one-hot rsp_vld equals the previous cycle's rd_gnt.
- **Forwarding:**
  - Condition: in the grant cycle, ram_ren & ram_wen & (ram_raddr == ram_waddr).
  - When the condition holds, register fwd_hit=1 together with wdata and wstrb.
  - Next cycle, for each lane i: rsp_data lane i = wstrb[i] ? fwd_wdata lane i : ram_rdata lane i.
  - Otherwise rsp_data = ram_rdata.
- **Zero-strobe write:** a write with wr_strb=0 is still granted and still advances wp. It forwards nothing, because no lane is selected.
- **Read/write independence:** a requester may hold rd_gnt and wr_gnt in the same cycle.
- **N=1:** the arbiter reduces to pass-through. The pointers stay 0.

## Timing

- **Grant latency:** grant is combinational, so it appears in the same cycle as the request.
- **Read latency:** with a grant at cycle T, rsp_vld and rsp_data are valid in cycle T+1 only. A response cannot be backpressured, so the requester must sink it.
- **Throughput:** one read and one write per cycle, sustained, across all requesters.
- **Back-to-back reads:** a new read is granted in T+1 while the response for T is presented.
- **Reset values:**
  - rp=0, wp=0, rsp_vld=0, fwd_hit=0.
  - While rst=1: rd_gnt=0, wr_gnt=0, ram_ren=0, ram_wen=0.
  - rsp_data is don't-care while rsp_vld=0.
- **Reset mid-operation:** a read granted in cycle T with rst=1 at the T+1 edge produces no response (rsp_vld=0 in T+1). Any write already granted has been committed by the RAM.
- **Write-then-read to the same address in consecutive cycles:** the RAM already holds the data, so no forwarding is needed.

## Test plan

- **Single read:**
  - Preload addr 0x0010=0xDEADBEEF. Requester 1 reads 0x0010.
  - Expect rd_gnt=2'b10 in T, rsp_vld=2'b10 in T+1, rsp_data=0xDEADBEEF.
- **Round-robin:**
  - Both requesters hold rd_req for 4 cycles.
  - Expect grants 01,10,01,10 and each response tagged to the matching requester.
- **Forward partial:**
  - Addr 0x0020=0x11112222. In the same cycle, requester 0 writes 0xAAAABBBB with strb=2'b10 while requester 1 reads 0x0020.
  - Expect rsp_data=0xAAAA2222.
  - A read of 0x0020 in a later cycle also returns 0xAAAA2222.
- **Zero strobe:**
  - Write with strb=0 to 0x0030 (holding 0x12345678) plus a same-cycle read.
  - Expect rsp_data=0x12345678, and wp advances.
- **Reset mid-read:**
  - Grant a read at T and assert rst at the T+1 edge.
  - Expect rsp_vld=0 in T+1. After rst drops, both pointers are 0, so requester 0 wins first under contention.
- **Concurrent independence:**
  - Requester 0 reads and requester 1 writes to different addresses every cycle for 8 cycles.
  - Expect ram_ren=ram_wen=1 on all 8 cycles and no forwarding.

Source files
------------

// File: rtl/dpram_arb.sv
// dpram_arb
// Round-robin front end that shares one dual-port RAM (registered read port,
// byte-strobed write port) between N requesters. Read and write sides are
// arbitrated independently, each with its own rotating priority pointer.
// Read responses come back one cycle after the grant, tagged one-hot to the
// winner. A write landing on the address being read in the same cycle is
// merged lane-by-lane into the response, so users see write-first behaviour.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   rd_req/rd_addr        per-requester read request and address (i at [i*A+:A])
//   rd_gnt                combinational one-hot read grant
//   rsp_vld/rsp_data      registered one-hot response tag and shared data
//   wr_req/wr_addr/
//   wr_data/wr_strb       per-requester write request, address, data, lane strobes
//   wr_gnt                combinational one-hot write grant
//   ram_ren/ram_raddr     RAM read port drive; ram_rdata returns one cycle later
//   ram_wen/ram_waddr/
//   ram_wdata/ram_wstrb   RAM write port drive
module dpram_arb #(
    parameter int N = 2,
    parameter int A = 16,
    parameter int D = 32,
    parameter int S = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   rd_req,
    input  logic [N*A-1:0] rd_addr,
    output logic [N-1:0]   rd_gnt,
    output logic [N-1:0]   rsp_vld,
    output logic [D-1:0]   rsp_data,
    input  logic [N-1:0]   wr_req,
    input  logic [N*A-1:0] wr_addr,
    input  logic [N*D-1:0] wr_data,
    input  logic [N*S-1:0] wr_strb,
    output logic [N-1:0]   wr_gnt,
    output logic           ram_ren,
    output logic [A-1:0]   ram_raddr,
    input  logic [D-1:0]   ram_rdata,
    output logic           ram_wen,
    output logic [A-1:0]   ram_waddr,
    output logic [D-1:0]   ram_wdata,
    output logic [S-1:0]   ram_wstrb
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int E  = D / S;

    logic [PW-1:0]  r_rp;
    logic [PW-1:0]  r_wp;
    logic [N-1:0]   r_rsp_vld;
    logic           r_fwd_hit;
    logic [D-1:0]   r_fwd_wdata;
    logic [S-1:0]   r_fwd_wstrb;

    logic [2*N-1:0] w_rd_dbl;
    logic [N-1:0]   w_rd_rot;
    logic [N-1:0]   w_rd_pick;
    logic [2*N-1:0] w_rd_back;
    logic [N-1:0]   w_rd_gnt;
    logic [PW-1:0]  w_rd_idx;
    logic [PW-1:0]  w_rp_next;

    logic [2*N-1:0] w_wr_dbl;
    logic [N-1:0]   w_wr_rot;
    logic [N-1:0]   w_wr_pick;
    logic [2*N-1:0] w_wr_back;
    logic [N-1:0]   w_wr_gnt;
    logic [PW-1:0]  w_wr_idx;
    logic [PW-1:0]  w_wp_next;

    logic           w_ren;
    logic           w_wen;
    logic [A-1:0]   w_raddr;
    logic [A-1:0]   w_waddr;
    logic [D-1:0]   w_wdata;
    logic [S-1:0]   w_wstrb;
    logic           w_fwd;
    logic [D-1:0]   w_rsp_data;

    // Rotate requests so the pointer index sits at bit 0, isolate the lowest
    // set bit (first requester in scan order), then rotate the pick back.
    always_comb begin
        w_rd_dbl  = {rd_req, rd_req} >> r_rp;
        w_rd_rot  = w_rd_dbl[N-1:0];
        w_rd_pick = w_rd_rot & (~w_rd_rot + N'(1));
        w_rd_back = {w_rd_pick, w_rd_pick} << r_rp;
        w_rd_gnt  = rst ? '0 : w_rd_back[2*N-1:N];

        w_wr_dbl  = {wr_req, wr_req} >> r_wp;
        w_wr_rot  = w_wr_dbl[N-1:0];
        w_wr_pick = w_wr_rot & (~w_wr_rot + N'(1));
        w_wr_back = {w_wr_pick, w_wr_pick} << r_wp;
        w_wr_gnt  = rst ? '0 : w_wr_back[2*N-1:N];
    end

    // Port muxes default to requester 0 so idle outputs are deterministic.
    always_comb begin
        w_rd_idx = '0;
        w_raddr  = rd_addr[A-1:0];
        w_wr_idx = '0;
        w_waddr  = wr_addr[A-1:0];
        w_wdata  = wr_data[D-1:0];
        w_wstrb  = wr_strb[S-1:0];
        for (int unsigned i = 0; i < N; i++) begin
            if (w_rd_gnt[i]) begin
                w_rd_idx = PW'(i);
                w_raddr  = rd_addr[i*A +: A];
            end
            if (w_wr_gnt[i]) begin
                w_wr_idx = PW'(i);
                w_waddr  = wr_addr[i*A +: A];
                w_wdata  = wr_data[i*D +: D];
                w_wstrb  = wr_strb[i*S +: S];
            end
        end
        w_ren     = |w_rd_gnt;
        w_wen     = |w_wr_gnt;
        w_fwd     = w_ren & w_wen & (w_raddr == w_waddr);
        w_rp_next = (w_rd_idx == PW'(N-1)) ? '0 : w_rd_idx + PW'(1);
        w_wp_next = (w_wr_idx == PW'(N-1)) ? '0 : w_wr_idx + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rp        <= '0;
            r_wp        <= '0;
            r_rsp_vld   <= '0;
            r_fwd_hit   <= 1'b0;
            r_fwd_wdata <= '0;
            r_fwd_wstrb <= '0;
        end else begin
            if (w_ren) begin
                r_rp <= w_rp_next;
            end
            if (w_wen) begin
                r_wp <= w_wp_next;
            end
            r_rsp_vld   <= w_rd_gnt;
            r_fwd_hit   <= w_fwd;
            r_fwd_wdata <= w_wdata;
            r_fwd_wstrb <= w_wstrb;
        end
    end

    // The RAM returns pre-write data on a same-address collision; patch in
    // only the lanes the colliding write actually strobed.
    always_comb begin
        w_rsp_data = ram_rdata;
        for (int unsigned l = 0; l < S; l++) begin
            if (r_fwd_hit && r_fwd_wstrb[l]) begin
                w_rsp_data[l*E +: E] = r_fwd_wdata[l*E +: E];
            end
        end
    end

    assign rd_gnt    = w_rd_gnt;
    assign wr_gnt    = w_wr_gnt;
    assign rsp_vld   = r_rsp_vld;
    assign rsp_data  = w_rsp_data;
    assign ram_ren   = w_ren;
    assign ram_raddr = w_raddr;
    assign ram_wen   = w_wen;
    assign ram_waddr = w_waddr;
    assign ram_wdata = w_wdata;
    assign ram_wstrb = w_wstrb;

endmodule

// File: tb/tb_dpram_arb.sv
// tb_dpram_arb
// Directed bench for dpram_arb with a behavioural read-first DPRAM behind it.
// Stimulus pushes expected read responses into a scoreboard queue; a negedge
// monitor pops and compares whenever rsp_vld is presented.
module tb_dpram_arb;

    localparam int N = 2;
    localparam int A = 16;
    localparam int D = 32;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   rd_req;
    logic [N*A-1:0] rd_addr;
    logic [N-1:0]   rd_gnt;
    logic [N-1:0]   rsp_vld;
    logic [D-1:0]   rsp_data;
    logic [N-1:0]   wr_req;
    logic [N*A-1:0] wr_addr;
    logic [N*D-1:0] wr_data;
    logic [N*S-1:0] wr_strb;
    logic [N-1:0]   wr_gnt;
    logic           ram_ren;
    logic [A-1:0]   ram_raddr;
    logic [D-1:0]   ram_rdata;
    logic           ram_wen;
    logic [A-1:0]   ram_waddr;
    logic [D-1:0]   ram_wdata;
    logic [S-1:0]   ram_wstrb;

    always #5 clk = ~clk;

    dpram_arb #(.N(N), .A(A), .D(D), .S(S)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .wr_gnt(wr_gnt),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb)
    );

    // Read-first RAM model; contents are preloaded while rst is high.
    logic [D-1:0] mem [0:255];
    logic [D-1:0] merged;
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h20] <= 32'h11112222;
            mem[8'h30] <= 32'h12345678;
            mem[8'h40] <= 32'h40404040;
            mem[8'h41] <= 32'h41414141;
            for (int k = 0; k < 8; k++) mem[8'h50 + k] <= 32'h5000_0000 + k;
        end else if (ram_wen) begin
            merged = mem[ram_waddr[7:0]];
            for (int l = 0; l < S; l++)
                if (ram_wstrb[l]) merged[l*16 +: 16] = ram_wdata[l*16 +: 16];
            mem[ram_waddr[7:0]] <= merged;
        end
        if (ram_ren) ram_rdata <= mem[ram_raddr[7:0]];
    end

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct packed {
        int unsigned  cyc;
        logic [N-1:0] tag;
        logic [D-1:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0 && sb[0].cyc < cyc_cnt) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL rsp_missing: no response at cycle %0d expected tag %b data %h", e.cyc, e.tag, e.data);
        end
        if (rsp_vld !== '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got vld %b data %h expected no response", rsp_vld, rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc_cnt), 64'(e.cyc));
                chk("rsp_tag", 64'(rsp_vld), 64'(e.tag));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
            end
        end
    end

    task automatic expect_rsp(input logic [N-1:0] tag, input logic [D-1:0] data);
        exp_t e;
        e.cyc  = cyc_cnt + 1;
        e.tag  = tag;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic idle();
        rd_req  = '0;
        wr_req  = '0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_strb = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        rst = 1'b1;
        idle();
        rd_req = 2'b11;
        wr_req = 2'b11;
        @(negedge clk);
        chk("rst_rd_gnt", 64'(rd_gnt), 64'h0);
        chk("rst_wr_gnt", 64'(wr_gnt), 64'h0);
        chk("rst_ram_ren", 64'(ram_ren), 64'h0);
        chk("rst_ram_wen", 64'(ram_wen), 64'h0);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
        next();
        next();
        rst = 1'b0;
        idle();

        // No grant: address comes from requester 0
        rd_addr = {16'h5555, 16'h1234};
        @(negedge clk);
        chk("idle_ram_ren", 64'(ram_ren), 64'h0);
        chk("idle_raddr", 64'(ram_raddr), 64'h1234);
        next();
        idle();

        // Single read by requester 1
        rd_req = 2'b10;
        rd_addr[A +: A] = 16'h0010;
        @(negedge clk);
        chk("single_rd_gnt", 64'(rd_gnt), 64'h2);
        chk("single_ram_ren", 64'(ram_ren), 64'h1);
        chk("single_raddr", 64'(ram_raddr), 64'h0010);
        expect_rsp(2'b10, 32'hDEADBEEF);
        next();
        idle();

        // Round-robin, back-to-back
        rd_req  = 2'b11;
        rd_addr = {16'h0041, 16'h0040};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rr_rd_gnt", 64'(rd_gnt), 64'(rr_exp[c]));
            expect_rsp(rr_exp[c], (rr_exp[c] == 2'b01) ? 32'h40404040 : 32'h41414141);
            next();
        end
        idle();

        // Partial-strobe forward: req0 writes upper lane, req1 reads same address
        wr_req = 2'b01;
        wr_addr[0 +: A] = 16'h0020;
        wr_data[0 +: D] = 32'hAAAABBBB;
        wr_strb[0 +: S] = 2'b10;
        rd_req = 2'b10;
        rd_addr[A +: A] = 16'h0020;
        @(negedge clk);
        chk("fwd_wr_gnt", 64'(wr_gnt), 64'h1);
        chk("fwd_rd_gnt", 64'(rd_gnt), 64'h2);
        chk("fwd_waddr", 64'(ram_waddr), 64'h0020);
        chk("fwd_wdata", 64'(ram_wdata), 64'hAAAABBBB);
        chk("fwd_wstrb", 64'(ram_wstrb), 64'h2);
        expect_rsp(2'b10, 32'hAAAA2222);
        next();
        idle();
        rd_req = 2'b01;
        rd_addr[0 +: A] = 16'h0020;
        @(negedge clk);
        chk("fwd_reread_gnt", 64'(rd_gnt), 64'h1);
        expect_rsp(2'b01, 32'hAAAA2222);
        next();
        idle();

        // Zero-strobe write with same-cycle read (wp=1, rp=1 here)
        wr_req = 2'b10;
        wr_addr[A +: A] = 16'h0030;
        wr_data[D +: D] = 32'hFFFFFFFF;
        wr_strb[S +: S] = 2'b00;
        rd_req = 2'b10;
        rd_addr[A +: A] = 16'h0030;
        @(negedge clk);
        chk("zs_wr_gnt", 64'(wr_gnt), 64'h2);
        chk("zs_ram_wen", 64'(ram_wen), 64'h1);
        chk("zs_rd_gnt", 64'(rd_gnt), 64'h2);
        expect_rsp(2'b10, 32'h12345678);
        next();
        idle();
        // wp advanced to 0, so requester 0 wins write contention
        wr_req  = 2'b11;
        wr_addr = {16'h0071, 16'h0070};
        @(negedge clk);
        chk("zs_wp_adv", 64'(wr_gnt), 64'h1);
        next();
        idle();

        // Reset mid-read: leave rp=1, wp=1, then reset during a granted read
        rd_req = 2'b01;
        rd_addr[0 +: A] = 16'h0010;
        wr_req = 2'b01;
        wr_addr[0 +: A] = 16'h0070;
        @(negedge clk);
        chk("pre_rst_rd_gnt", 64'(rd_gnt), 64'h1);
        expect_rsp(2'b01, 32'hDEADBEEF);
        next();
        idle();
        rd_req = 2'b01;
        rd_addr[0 +: A] = 16'h0010;
        @(negedge clk);
        chk("midrst_rd_gnt", 64'(rd_gnt), 64'h1);
        rst = 1'b1;
        next();
        idle();
        @(negedge clk);
        chk("midrst_rsp_vld", 64'(rsp_vld), 64'h0);
        next();
        rst = 1'b0;
        rd_req  = 2'b11;
        rd_addr = {16'h0020, 16'h0010};
        wr_req  = 2'b11;
        wr_addr = {16'h0071, 16'h0070};
        @(negedge clk);
        chk("postrst_rd_gnt", 64'(rd_gnt), 64'h1);
        chk("postrst_wr_gnt", 64'(wr_gnt), 64'h1);
        expect_rsp(2'b01, 32'hDEADBEEF);
        next();
        idle();

        // Concurrent independent read (req0) and write (req1)
        for (int k = 0; k < 8; k++) begin
            rd_req = 2'b01;
            rd_addr[0 +: A] = 16'h0050 + 16'(k);
            wr_req = 2'b10;
            wr_addr[A +: A] = 16'h0060 + 16'(k);
            wr_data[D +: D] = 32'hC0DE0000 + 32'(k);
            wr_strb[S +: S] = 2'b11;
            @(negedge clk);
            chk("conc_ren", 64'(ram_ren), 64'h1);
            chk("conc_wen", 64'(ram_wen), 64'h1);
            chk("conc_rd_gnt", 64'(rd_gnt), 64'h1);
            chk("conc_wr_gnt", 64'(wr_gnt), 64'h2);
            chk("conc_waddr", 64'(ram_waddr), 64'h0060 + 64'(k));
            expect_rsp(2'b01, 32'h5000_0000 + 32'(k));
            next();
        end
        idle();

        // Read back one concurrent write through requester 1
        rd_req = 2'b10;
        rd_addr[A +: A] = 16'h0063;
        @(negedge clk);
        chk("rb_rd_gnt", 64'(rd_gnt), 64'h2);
        expect_rsp(2'b10, 32'hC0DE0003);
        next();
        idle();

        repeat (3) next();
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
